// File: rtl/uart_config_loader.sv
// Channel-configuration loader: assembles UART bytes MSB-first into a shadow
// register and commits a complete frame atomically to o_conf.
module uart_config_loader #(
  parameter int CHANNELS  = 8,
  parameter int CONF_BITS = 10,
  parameter int TIMEOUT   = 65535
) (
  input  logic                          i_clk,
  input  logic                          _rst,
  input  logic [7:0]                    i_data,
  input  logic                          i_avail,
  input  logic                          i_clr_err,
  output logic [CHANNELS*CONF_BITS-1:0] o_conf,
  output logic                          o_conf_valid,
  output logic                          o_busy,
  output logic                          o_abort,
  output logic                          o_overrun
);

  // state  | meaning
  // IDLE   | waiting for a byte; a partial frame may be held
  // SHIFT  | shifting the held byte into the shadow, one bit per clock
  // COMMIT | full frame in shadow, copy to o_conf

  localparam int TOTAL = CHANNELS * CONF_BITS;
  localparam int BYTES = (TOTAL + 7) / 8;
  localparam int SW    = BYTES * 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int IW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [BCW-1:0] LAST_BYTE  = BCW'(BYTES - 1);
  localparam logic [IW-1:0]  IDLE_LIMIT = IW'(TIMEOUT);
  localparam bit             TO_EN      = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t          state_q, state_d;
  logic            avail_q;
  logic [SW-1:0]   shadow;
  logic [7:0]      hold;
  logic [2:0]      bit_cnt;
  logic [BCW-1:0]  byte_cnt;
  logic [IW-1:0]   idle_cnt;
  logic            byte_edge;
  logic            latch_byte, do_shift, do_commit, do_timeout, idle_inc;

  assign byte_edge = i_avail & ~avail_q;
  assign o_busy    = (state_q != IDLE) | (byte_cnt != '0);

  always_ff @(posedge i_clk or negedge _rst) begin
    if (!_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    latch_byte = 1'b0;
    do_shift   = 1'b0;
    do_commit  = 1'b0;
    do_timeout = 1'b0;
    idle_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        // An arriving byte takes priority over an expiring timeout.
        if (byte_edge) begin
          latch_byte = 1'b1;
          state_d    = SHIFT;
        end else if (byte_cnt != '0) begin
          if (TO_EN && idle_cnt == IDLE_LIMIT) do_timeout = 1'b1;
          else                                 idle_inc   = 1'b1;
        end
      end
      SHIFT: begin
        do_shift = 1'b1;
        if (bit_cnt == 3'd7) state_d = (byte_cnt == LAST_BYTE) ? COMMIT : IDLE;
      end
      COMMIT: begin
        do_commit = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge _rst) begin
    if (!_rst) begin
      avail_q      <= 1'b0;
      shadow       <= '0;
      hold         <= '0;
      bit_cnt      <= '0;
      byte_cnt     <= '0;
      idle_cnt     <= '0;
      o_conf       <= '0;
      o_conf_valid <= 1'b0;
      o_abort      <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      avail_q      <= i_avail;
      o_conf_valid <= do_commit;
      o_abort      <= do_timeout;
      if (latch_byte) begin
        hold     <= i_data;
        bit_cnt  <= '0;
        idle_cnt <= '0;
      end
      if (idle_inc && idle_cnt != '1) idle_cnt <= idle_cnt + IW'(1);
      if (do_timeout) begin
        byte_cnt <= '0;
        shadow   <= '0;
        idle_cnt <= '0;
      end
      if (do_shift) begin
        shadow  <= {shadow[SW-2:0], hold[3'd7 - bit_cnt]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7 && byte_cnt != LAST_BYTE) byte_cnt <= byte_cnt + BCW'(1);
      end
      if (do_commit) begin
        o_conf   <= shadow[TOTAL-1:0];
        byte_cnt <= '0;
      end
      // A byte that cannot be taken is lost; setting beats a same-cycle clear.
      if (byte_edge && state_q != IDLE) o_overrun <= 1'b1;
      else if (i_clr_err)               o_overrun <= 1'b0;
    end
  end

endmodule
